// File: rtl/serial_in_receiver.sv
// Serial-input deserializer: synchronizes SID, frames start/8 data/stop bits LSB first,
// and produces the SERIN byte plus the SKSTAT status strobes.
module serial_in_receiver #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enn,
    input  logic       sid,
    input  logic       bitTick,
    input  logic       irqPend,
    output logic       timerSync,
    output logic [7:0] serin,
    output logic       serinRdy,
    output logic       sdiBusy,
    output logic       sdiOvrun,
    output logic       setFramer,
    output logic       siDelay
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     prev_sid_q;
    logic [7:0]               shift_q, shift_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               serin_q, serin_d;
    logic                     timer_sync_q, timer_sync_d;
    logic                     serin_rdy_q, serin_rdy_d;
    logic                     ovrun_q, ovrun_d;
    logic                     framer_q, framer_d;
    logic                     si_delay;
    logic                     start_edge;

    assign si_delay   = sync_q[SYNC_STAGES-1];
    assign start_edge = !si_delay && prev_sid_q;

    // Synchronizer and edge-detect history; idle line is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '1;
            prev_sid_q <= 1'b1;
        end else if (enn) begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sid};
            prev_sid_q <= si_delay;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        serin_d      = serin_q;
        timer_sync_d = 1'b0;
        serin_rdy_d  = 1'b0;
        ovrun_d      = 1'b0;
        framer_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d      = StStart;
                    timer_sync_d = 1'b1;
                end
            end
            StStart: begin
                if (bitTick) begin
                    // A high line at the start-bit centre was a glitch, not a frame.
                    if (!si_delay) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (bitTick) begin
                    shift_d   = {si_delay, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (bitTick) begin
                    serin_d     = shift_q;
                    serin_rdy_d = 1'b1;
                    framer_d    = !si_delay;
                    ovrun_d     = irqPend;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pulse registers reload every enn cycle, so each strobe spans one full enn period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            serin_q      <= 8'h00;
            timer_sync_q <= 1'b0;
            serin_rdy_q  <= 1'b0;
            ovrun_q      <= 1'b0;
            framer_q     <= 1'b0;
        end else if (enn) begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            serin_q      <= serin_d;
            timer_sync_q <= timer_sync_d;
            serin_rdy_q  <= serin_rdy_d;
            ovrun_q      <= ovrun_d;
            framer_q     <= framer_d;
        end
    end

    assign timerSync = timer_sync_q;
    assign serin     = serin_q;
    assign serinRdy  = serin_rdy_q;
    assign sdiBusy   = (state_q != StIdle);
    assign sdiOvrun  = ovrun_q;
    assign setFramer = framer_q;
    assign siDelay   = si_delay;

endmodule

// File: tb/tb_serial_in_receiver.sv
// Scenario bench for serial_in_receiver: frames are driven bit by bit, expected bytes and
// strobes are queued at the stop tick and popped when serinRdy pulses.
module tb_serial_in_receiver;

    logic       clk;
    logic       reset;
    logic       enn;
    logic       sid;
    logic       bitTick;
    logic       irqPend;
    logic       timerSync;
    logic [7:0] serin;
    logic       serinRdy;
    logic       sdiBusy;
    logic       sdiOvrun;
    logic       setFramer;
    logic       siDelay;

    int n_checks = 0;
    int n_fail   = 0;

    // {byte, framing error, overrun}
    logic [9:0] exp_q[$];

    int rdy_seen = 0;
    int ts_seen  = 0;
    int fr_seen  = 0;
    int ov_seen  = 0;
    bit rdy_prev = 0;
    bit ts_prev  = 0;
    bit fr_prev  = 0;
    bit ov_prev  = 0;

    serial_in_receiver #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .enn      (enn),
        .sid      (sid),
        .bitTick  (bitTick),
        .irqPend  (irqPend),
        .timerSync(timerSync),
        .serin    (serin),
        .serinRdy (serinRdy),
        .sdiBusy  (sdiBusy),
        .sdiOvrun (sdiOvrun),
        .setFramer(setFramer),
        .siDelay  (siDelay)
    );

    always #5 clk = ~clk;

    // One clock: sample #1 after the edge, count strobe rising edges, drain scoreboard.
    task automatic step();
        logic [9:0] exp_v;
        @(posedge clk);
        #1;
        if (serinRdy && !rdy_prev) begin
            rdy_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: serinRdy with serin=%h, none expected", serin);
            end else begin
                exp_v = exp_q.pop_front();
                if ({serin, setFramer, sdiOvrun} !== exp_v) begin
                    n_fail++;
                    $display("FAIL sb_frame: got serin=%h fr=%b ov=%b, want serin=%h fr=%b ov=%b",
                             serin, setFramer, sdiOvrun, exp_v[9:2], exp_v[1], exp_v[0]);
                end
            end
        end
        if (timerSync && !ts_prev) ts_seen++;
        if (setFramer && !fr_prev) fr_seen++;
        if (sdiOvrun && !ov_prev) ov_seen++;
        rdy_prev = serinRdy;
        ts_prev  = timerSync;
        fr_prev  = setFramer;
        ov_prev  = sdiOvrun;
    endtask

    task automatic do_reset();
        bitTick = 1'b0;
        reset   = 1'b1;
        step();
        step();
        reset   = 1'b0;
    endtask

    task automatic idle(input int n);
        sid     = 1'b1;
        bitTick = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Drive one frame; ticks every 16 clocks starting 8 after timerSync. abort_ticks>0
    // resets the DUT after that many ticks instead of completing the frame.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic irq,
                              input int abort_ticks);
        int ts_c;
        int ticks;
        int seg;
        bit busy_bad;
        ts_c     = -1;
        ticks    = 0;
        busy_bad = 0;
        irqPend  = irq;
        for (int c = 0; c < 400; c++) begin
            seg = c / 16;
            if (seg == 0) sid = 1'b0;
            else if (seg <= 8) sid = data[seg-1];
            else sid = stop;
            bitTick = (ts_c >= 0 && ticks < 10 && c >= ts_c + 8 && ((c - ts_c - 8) % 16) == 0);
            if (bitTick) ticks++;
            if (bitTick && ticks == 10) exp_q.push_back({data, ~stop, irq});
            step();
            if (ts_c < 0 && timerSync) ts_c = c;
            if (ts_c < 0 && c >= 10) begin
                n_checks++;
                n_fail++;
                $display("FAIL timer_sync_timeout: no timerSync after %0d clocks, want 1 pulse", c);
                break;
            end
            if (abort_ticks > 0 && ticks == abort_ticks) begin
                do_reset();
                break;
            end
            if (ticks == 10) begin
                n_checks++;
                if (sdiBusy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_after_stop: sdiBusy=%b, want 0", sdiBusy);
                end
                break;
            end
            if (ts_c >= 0 && sdiBusy !== 1'b1) busy_bad = 1;
        end
        bitTick = 1'b0;
        sid     = 1'b1;
        irqPend = 1'b0;
        if (abort_ticks == 0) begin
            n_checks++;
            if (busy_bad) begin
                n_fail++;
                $display("FAIL busy_in_frame: sdiBusy dropped mid-frame, want 1");
            end
        end
    endtask

    task automatic check_counts(input string name, input int d_rdy, input int d_fr,
                                input int d_ov, input int w_rdy, input int w_fr, input int w_ov);
        n_checks++;
        if (d_rdy !== w_rdy || d_fr !== w_fr || d_ov !== w_ov) begin
            n_fail++;
            $display("FAIL %s_strobes: rdy/fr/ov=%0d/%0d/%0d, want %0d/%0d/%0d",
                     name, d_rdy, d_fr, d_ov, w_rdy, w_fr, w_ov);
        end
    endtask

    task automatic test_reset();
        enn     = 1'b1;
        sid     = 1'b1;
        bitTick = 1'b0;
        irqPend = 1'b0;
        do_reset();
        n_checks++;
        if ({serin, serinRdy, sdiOvrun, setFramer, timerSync, sdiBusy, siDelay} !== 14'h0001) begin
            n_fail++;
            $display("FAIL reset_state: serin=%h rdy=%b ov=%b fr=%b ts=%b busy=%b si=%b, want 00 0 0 0 0 0 1",
                     serin, serinRdy, sdiOvrun, setFramer, timerSync, sdiBusy, siDelay);
        end
        idle(4);
    endtask

    task automatic test_nominal();
        int r0, f0, o0, t0;
        r0 = rdy_seen; f0 = fr_seen; o0 = ov_seen; t0 = ts_seen;
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        idle(4);
        check_counts("nominal", rdy_seen - r0, fr_seen - f0, ov_seen - o0, 1, 0, 0);
        n_checks++;
        if (serin !== 8'hA5 || ts_seen - t0 !== 1) begin
            n_fail++;
            $display("FAIL nominal_serin: serin=%h ts=%0d, want a5 1", serin, ts_seen - t0);
        end
    endtask

    task automatic test_framing();
        int r0, f0, o0;
        r0 = rdy_seen; f0 = fr_seen; o0 = ov_seen;
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        idle(6);
        check_counts("framing", rdy_seen - r0, fr_seen - f0, ov_seen - o0, 1, 1, 0);
        n_checks++;
        if (serin !== 8'h3C) begin
            n_fail++;
            $display("FAIL framing_serin: serin=%h, want 3c", serin);
        end
    endtask

    task automatic test_overrun();
        int r0, f0, o0;
        r0 = rdy_seen; f0 = fr_seen; o0 = ov_seen;
        send_frame(8'h01, 1'b1, 1'b1, 0);
        idle(4);
        check_counts("overrun", rdy_seen - r0, fr_seen - f0, ov_seen - o0, 1, 0, 1);
        n_checks++;
        if (serin !== 8'h01) begin
            n_fail++;
            $display("FAIL overrun_serin: serin=%h, want 01", serin);
        end
    endtask

    task automatic test_false_start();
        int r0, t0;
        logic [7:0] s0;
        r0 = rdy_seen; t0 = ts_seen; s0 = serin;
        for (int c = 0; c < 10; c++) begin
            sid     = (c < 3) ? 1'b0 : 1'b1;
            bitTick = (c == 9);
            step();
        end
        bitTick = 1'b0;
        n_checks++;
        if (sdiBusy !== 1'b0 || ts_seen - t0 !== 1) begin
            n_fail++;
            $display("FAIL false_start_busy: busy=%b ts=%0d, want 0 1", sdiBusy, ts_seen - t0);
        end
        idle(20);
        n_checks++;
        if (serin !== s0 || rdy_seen - r0 !== 0) begin
            n_fail++;
            $display("FAIL false_start_data: serin=%h rdy=%0d, want %h 0", serin, rdy_seen - r0, s0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int r0, f0, o0;
        r0 = rdy_seen; f0 = fr_seen; o0 = ov_seen;
        send_frame(8'hFF, 1'b1, 1'b0, 5);
        n_checks++;
        if (serin !== 8'h00 || sdiBusy !== 1'b0 || siDelay !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_frame: serin=%h busy=%b si=%b, want 00 0 1",
                     serin, sdiBusy, siDelay);
        end
        idle(4);
        check_counts("reset_mid", rdy_seen - r0, fr_seen - f0, ov_seen - o0, 0, 0, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        idle(4);
        n_checks++;
        if (serin !== 8'h5A) begin
            n_fail++;
            $display("FAIL after_reset_frame: serin=%h, want 5a", serin);
        end
    endtask

    task automatic test_enn_gating();
        int r0, t0;
        logic [7:0] s0;
        bit moved;
        r0 = rdy_seen; t0 = ts_seen; s0 = serin; moved = 0;
        enn = 1'b0;
        for (int i = 0; i < 24; i++) begin
            sid     = i[0];
            bitTick = (i % 3) == 0;
            step();
            if (siDelay !== 1'b1 || sdiBusy !== 1'b0 || serin !== s0) moved = 1;
        end
        sid     = 1'b1;
        bitTick = 1'b0;
        step();
        enn = 1'b1;
        n_checks++;
        if (moved || rdy_seen - r0 !== 0 || ts_seen - t0 !== 0) begin
            n_fail++;
            $display("FAIL enn_gating: moved=%b rdy=%0d ts=%0d serin=%h, want 0 0 0 %h",
                     moved, rdy_seen - r0, ts_seen - t0, serin, s0);
        end
        idle(4);
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = rdy_seen;
        send_frame(8'h12, 1'b1, 1'b0, 0);
        send_frame(8'h34, 1'b1, 1'b0, 0);
        idle(4);
        n_checks++;
        if (rdy_seen - r0 !== 2 || serin !== 8'h34) begin
            n_fail++;
            $display("FAIL back_to_back: rdy=%0d serin=%h, want 2 34", rdy_seen - r0, serin);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d frames outstanding, want 0", exp_q.size());
        end
    endtask

    initial begin
        clk     = 1'b0;
        reset   = 1'b1;
        enn     = 1'b1;
        sid     = 1'b1;
        bitTick = 1'b0;
        irqPend = 1'b0;
        test_reset();
        test_nominal();
        test_framing();
        test_overrun();
        test_false_start();
        test_reset_mid_frame();
        test_enn_gating();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
